// File: rtl/reaction_timer_core.sv
// Reaction timer: random LFSR-derived wait, LED stimulus, BCD millisecond count.
// Optional cheat detection (stop during the wait) enabled by RT_CHEAT_DETECT_EN.
module reaction_timer_core #(
  parameter int          CLK_HZ       = 100000000,
  parameter int          MS_DIV       = CLK_HZ / 1000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        led,
  output logic [15:0] bcd,
  output logic        result_valid,
  output logic        timeout,
  output logic        early
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int WW = $clog2(MIN_DELAY_MS + 2048) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [15:0]     lfsr_r;
  logic [PW-1:0]   presc_r, presc_s;
  logic [WW-1:0]   wcnt_r, wcnt_s;
  logic [15:0]     bcd_s, bcd_inc_s;
  logic            timeout_s, early_s;
  logic            tick_s, start_ok_s, last_tick_s, cheat_stop_s;

  function automatic logic [15:0] bcd_add1(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c && (r[i*4 +: 4] == 4'd9)) begin
        r[i*4 +: 4] = 4'd0;
      end else if (c) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction

  assign tick_s      = ((state_r == S_WAIT) || (state_r == S_TIMING)) && (presc_r == PRESC_MAX);
  assign start_ok_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_FAULT));
  assign bcd_inc_s   = (bcd == 16'h9999) ? bcd : bcd_add1(bcd);
  assign last_tick_s = tick_s && (state_r == S_TIMING) && (bcd_inc_s == 16'h9999);

`ifdef RT_CHEAT_DETECT_EN
  assign cheat_stop_s = stop && (state_r == S_WAIT);
`else
  assign cheat_stop_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; stop outranks the final 9999 tick
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) state_s = S_WAIT;
        else       state_s = state_r;
      end
      S_WAIT: begin
        if (cheat_stop_s)                        state_s = S_FAULT;
        else if (tick_s && (wcnt_r <= WW'(1)))   state_s = S_TIMING;
        else                                     state_s = S_WAIT;
      end
      S_TIMING: begin
        if (stop || last_tick_s) state_s = S_DONE;
        else                     state_s = S_TIMING;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath next values: prescaler, wait counter, BCD count and flags
  always_comb begin
    presc_s   = presc_r;
    wcnt_s    = wcnt_r;
    bcd_s     = bcd;
    timeout_s = timeout;
    early_s   = early;

    if (state_s != state_r) presc_s = '0;
    else if (tick_s)        presc_s = '0;
    else if ((state_r == S_WAIT) || (state_r == S_TIMING)) presc_s = presc_r + PW'(1);
    else                    presc_s = '0;

    if (start_ok_s)                                        wcnt_s = WW'(MIN_DELAY_MS) + WW'(lfsr_r[10:0]);
    else if ((state_r == S_WAIT) && tick_s && (wcnt_r != '0)) wcnt_s = wcnt_r - WW'(1);
    else                                                   wcnt_s = wcnt_r;

    if (start_ok_s)                            bcd_s = 16'h0000;
    else if ((state_r == S_TIMING) && tick_s)  bcd_s = bcd_inc_s;
    else if (cheat_stop_s)                     bcd_s = 16'h0000;
    else                                       bcd_s = bcd;

    if (start_ok_s)                  timeout_s = 1'b0;
    else if (last_tick_s && !stop)   timeout_s = 1'b1;
    else                             timeout_s = timeout;

`ifdef RT_CHEAT_DETECT_EN
    if (start_ok_s)        early_s = 1'b0;
    else if (cheat_stop_s) early_s = 1'b1;
    else                   early_s = early;
`else
    early_s = 1'b0;
`endif
  end

  // Registered outputs and datapath; led/result_valid decode the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r      <= '0;
      wcnt_r       <= '0;
      bcd          <= 16'h0000;
      timeout      <= 1'b0;
      early        <= 1'b0;
      led          <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      presc_r      <= presc_s;
      wcnt_r       <= wcnt_s;
      bcd          <= bcd_s;
      timeout      <= timeout_s;
      early        <= early_s;
      led          <= (state_s == S_TIMING);
      result_valid <= (state_s == S_DONE);
    end
  end

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed scoreboard bench for reaction_timer_core (MS_DIV=4, MIN_DELAY_MS=2).
// A second instance shares all stimulus except an extra stop used for the 9999 race.
module tb_reaction_timer_core;

  localparam int MSD = 4;
  localparam int MIN = 2;

  logic clk = 1'b0;
  logic rst_n, start, stop, stop_x;
  logic stop_b;
  logic led_a, rv_a, to_a, early_a;
  logic [15:0] bcd_a;
  logic led_b, rv_b, to_b, early_b;
  logic [15:0] bcd_b;
  logic [15:0] m_lfsr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } sb_t;
  sb_t sb[$];

  assign stop_b = stop | stop_x;

  reaction_timer_core #(.MS_DIV(MSD), .MIN_DELAY_MS(MIN)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .led(led_a), .bcd(bcd_a), .result_valid(rv_a), .timeout(to_a), .early(early_a));

  reaction_timer_core #(.MS_DIV(MSD), .MIN_DELAY_MS(MIN)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop_b),
    .led(led_b), .bcd(bcd_b), .result_valid(rv_b), .timeout(to_b), .early(early_b));

  always #5 clk = ~clk;

  // Reference LFSR used to predict the captured random delay
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // No BCD digit may ever leave the 0..9 range
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ((bcd_a[3:0] <= 4'd9) && (bcd_a[7:4] <= 4'd9) &&
              (bcd_a[11:8] <= 4'd9) && (bcd_a[15:12] <= 4'd9))
      else begin
        failures++;
        $error("FAIL bcd_nibble observed=%h expected=all digits <= 9", bcd_a);
      end
    end
  end

  function automatic logic [19:0] ev(input logic l, input logic r, input logic t,
                                     input logic e, input logic [15:0] b);
    return {l, r, t, e, b};
  endfunction

  function automatic logic [19:0] vec_a();
    return {led_a, rv_a, to_a, early_a, bcd_a};
  endfunction

  function automatic logic [19:0] vec_b();
    return {led_b, rv_b, to_b, early_b, bcd_b};
  endfunction

  task automatic expect_v(input string tag, input logic [19:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_v(input logic [19:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty observed=%h expected=queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  // Wait until the reference LFSR offers a short delay, keeping the run brief
  task automatic wait_lucky();
    int n;
    n = 0;
    while ((m_lfsr[10:0] >= 11'd32) && (n < 5000)) begin
      tick(1);
      n++;
    end
  endtask

  task automatic start_trial(output int d, input logic with_stop);
    d = MIN + int'(m_lfsr[10:0]);
    start = 1'b1;
    stop  = with_stop;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Measure cycles until led rises; off = cycles already spent since WAIT entry
  task automatic wait_led(input string tag, input int d, input int off);
    int cnt;
    cnt = 0;
    expect_v(tag, 20'(MSD * d - off));
    while ((led_a !== 1'b1) && (cnt < 20000)) begin
      tick(1);
      cnt++;
    end
    check_v(20'(cnt));
  endtask

  initial begin
    int d, d_first, hi;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; stop_x = 1'b0;
    tick(3);
    expect_v("reset_state", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    rst_n = 1'b1;

    // First trial: stop in IDLE ignored, start at cycle 10, stop after 37 ticks
    tick(5);
    pulse_stop();
    expect_v("idle_stop_ignored", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    tick(4);
    start_trial(d_first, 1'b0);
    expect_v("wait_entry", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    wait_led("delay_first", d_first, 0);
    expect_v("timing_entry", ev(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    tick(40);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    expect_v("timing_start_ignored", ev(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010));
    check_v(vec_a());
    tick(107);
    pulse_stop();
    expect_v("stop_37", ev(1'b0, 1'b1, 1'b0, 1'b0, 16'h0037));
    check_v(vec_a());
    pulse_stop();
    tick(99);
    expect_v("frozen_37", ev(1'b0, 1'b1, 1'b0, 1'b0, 16'h0037));
    check_v(vec_a());

    // Start and stop together in DONE: start wins; then count to 1000
    wait_lucky();
    start_trial(d, 1'b1);
    expect_v("done_start_stop", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    wait_led("delay_1000", d, 0);
    tick(MSD * 1000);
    expect_v("count_1000", ev(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000));
    check_v(vec_a());
    pulse_stop();
    expect_v("stop_1000", ev(1'b0, 1'b1, 1'b0, 1'b0, 16'h1000));
    check_v(vec_a());

    // Stop during WAIT
    wait_lucky();
    start_trial(d, 1'b0);
    tick(5);
    pulse_stop();
`ifdef RT_CHEAT_DETECT_EN
    expect_v("cheat_fault", ev(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000));
    check_v(vec_a());
    hi = 0;
    repeat (MSD * d + 20) begin
      tick(1);
      if (led_a !== 1'b0) hi++;
    end
    expect_v("cheat_led_quiet", 20'd0);
    check_v(20'(hi));
    wait_lucky();
    start_trial(d, 1'b0);
    expect_v("cheat_cleared", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    wait_led("delay_after_fault", d, 0);
`else
    expect_v("wait_stop_ignored", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    wait_led("delay_wait_stop", d, 6);
`endif
    pulse_stop();
    expect_v("stop_immediate", ev(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());

    // Reset mid-trial at 0512, then repeat the seed-derived first delay
    wait_lucky();
    start_trial(d, 1'b0);
    wait_led("delay_pre_reset", d, 0);
    tick(MSD * 512);
    expect_v("count_0512", ev(1'b1, 1'b0, 1'b0, 1'b0, 16'h0512));
    check_v(vec_a());
    rst_n = 1'b0;
    #1;
    expect_v("async_reset", ev(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());
    tick(1);
    rst_n = 1'b1;
    tick(10);
    start_trial(d, 1'b0);
    wait_led("delay_after_reset", d_first, 0);
    pulse_stop();
    expect_v("stop_after_reset", ev(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000));
    check_v(vec_a());

    // Full-range run: A times out, B stops on the same 9999 tick
    wait_lucky();
    start_trial(d, 1'b0);
    wait_led("delay_9999", d, 0);
    tick(MSD * 9999 - 2);
    expect_v("count_9998", ev(1'b1, 1'b0, 1'b0, 1'b0, 16'h9998));
    check_v(vec_a());
    tick(1);
    stop_x = 1'b1;
    tick(1);
    stop_x = 1'b0;
    expect_v("timeout_9999", ev(1'b0, 1'b1, 1'b1, 1'b0, 16'h9999));
    check_v(vec_a());
    expect_v("stop_race_9999", ev(1'b0, 1'b1, 1'b0, 1'b0, 16'h9999));
    check_v(vec_b());
    tick(20);
    expect_v("timeout_hold", ev(1'b0, 1'b1, 1'b1, 1'b0, 16'h9999));
    check_v(vec_a());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
REACTION_TIMER_CORE -- requirements
Module: reaction_timer_core

Interface
REQ-001 Parameter: CLK_HZ, 100000000, input clock frequency.
REQ-002 Parameter: MS_DIV, CLK_HZ/1000, clock cycles per millisecond tick; benches override it with a small value.
REQ-003 Parameter: MIN_DELAY_MS, 1000, minimum random wait before the LED lights.
REQ-004 Parameter: LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
REQ-005 Port: clk, input, 1, single system clock, rising edge.
REQ-006 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port: start, input, 1, one-cycle synchronous pulse from the upstream debouncer that begins a trial.
REQ-008 Port: stop, input, 1, one-cycle synchronous pulse from the upstream debouncer that ends timing.
REQ-009 Port: led, output, 1, stimulus LED, high only in TIMING.
REQ-010 Port: bcd, output, 16, elapsed ms as 4 BCD digits for the downstream 7-segment display stage; [15:12] is thousands.
REQ-011 Port: result_valid, output, 1, high in DONE.
REQ-012 Port: timeout, output, 1, high when the trial ended at 9999 ms without a stop.
REQ-013 Port: early, output, 1, cheat flag (see Configuration).

Function
REQ-014 States: IDLE, WAIT, TIMING, DONE, FAULT. The encoding is implementation choice.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) shall step every clk cycle in every state.
REQ-016 A start pulse in IDLE, DONE or FAULT shall capture delay_ms = MIN_DELAY_MS + lfsr[10:0], clear bcd, timeout, early and the ms prescaler, and enter WAIT on the next cycle.
REQ-017 start shall be ignored in WAIT and TIMING.
REQ-018 In WAIT, a down-counter shall decrement once per ms tick; on reaching 0 the FSM enters TIMING and led rises in that same transition cycle.
REQ-019 In TIMING, bcd shall increment by 1 per ms tick with decimal carry across all digits. The first increment occurs MS_DIV cycles after TIMING entry.
REQ-020 A stop pulse in TIMING shall freeze bcd, clear led and enter DONE on the next cycle; result_valid rises in that cycle.
REQ-021 If bcd reaches 16'h9999 in TIMING, bcd saturates at 9999, the FSM enters DONE, and timeout=1.
REQ-022 If stop and the 9999 tick occur in the same cycle, the stop takes priority: timeout=0 and bcd=9999.
REQ-023 If start and stop arrive in the same cycle in DONE or FAULT, start governs and stop is ignored.
REQ-024 stop in IDLE or DONE shall be ignored.
REQ-025 The ms prescaler counts 0..MS_DIV-1 and wraps. Its tick is valid only in WAIT and TIMING, and the prescaler restarts at 0 on each state entry.

Reset
REQ-026 While rst_n=0, and asynchronously on its assertion: state=IDLE, led=0, bcd=16'h0000, result_valid=0, timeout=0, early=0, prescaler=0, wait counter=0, lfsr=LFSR_SEED.
REQ-027 Reset asserted mid-trial shall abort the trial with no residual flags. Operation resumes on the first clk edge after deassertion.

Configuration
REQ-028 Macro RT_CHEAT_DETECT_EN, defined:
- stop in WAIT enters FAULT with early=1, led=0 and bcd=16'h0000.
- FAULT is left only by start or reset.
REQ-029 Macro RT_CHEAT_DETECT_EN, undefined:
- stop in WAIT is ignored.
- FAULT is unreachable.
- early is tied to 0.

Verification (MS_DIV=4, MIN_DELAY_MS=2)
REQ-030 Reset release, then start at cycle 10 -> WAIT entered, led stays 0 for exactly (2+lfsr[10:0] captured)*4 cycles, then led=1.
REQ-031 stop issued 37 ms ticks after led rises -> bcd=16'h0037, result_valid=1, led=0, timeout=0, and bcd stays frozen for 100 further cycles.
REQ-032 No stop for 9999 ticks in TIMING -> bcd=16'h9999, timeout=1, result_valid=1; a stop on the same cycle as the 9999 tick gives timeout=0.
REQ-033 With RT_CHEAT_DETECT_EN, stop during WAIT -> early=1, state FAULT, led never rises; a following start clears early. Without the macro, the same stimulus leaves the trial proceeding normally.
REQ-034 rst_n pulsed low during TIMING at bcd=16'h0512 -> all outputs are 0 immediately; the next start yields a delay computed from LFSR_SEED-derived sequence.
REQ-035 Decimal carry: stop at 1000 ticks -> bcd=16'h1000, with no nibble ever exceeding 9 during the count, as checked by an assertion.
